// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16_if: byte hand-off channel between the UART receiver and its consumer.
//
// Signals:
//   rx_data  - last accepted byte (receiver -> consumer)
//   rx_valid - rx_data holds an unread byte (receiver -> consumer)
//   rx_ack   - consumer takes the byte, qualified by rx_valid (consumer -> receiver)
//
// Modports:
//   master - receiver side: drives rx_data/rx_valid, samples rx_ack
//   slave  - consumer side: samples rx_data/rx_valid, drives rx_ack
interface uart_rx_os16_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: single-clock UART receiver, 16x oversampling, internal baud-tick generator.
// Frames are 8N1, or 8E1 when UART_RX_PARITY_EN is defined (adds the parity state and
// parity_err; without it parity_err is tied low).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high
//   rx_in      - asynchronous serial line, idle high
//   rx_bus     - byte hand-off (master modport): rx_data, rx_valid out; rx_ack in
//   rx_busy    - a frame is in progress
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   parity_err - one-cycle pulse on even-parity mismatch
//   overrun    - sticky, a byte was dropped because rx_valid was still set
module uart_rx_os16 #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DIV      = CLK_FREQ / (16 * BAUD)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_in,
    uart_rx_os16_if.master rx_bus,
    output logic           rx_busy,
    output logic           frame_err,
    output logic           parity_err,
    output logic           overrun
);

    localparam logic [15:0] DivLast = 16'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] div_cnt_q;
    logic        tick;
    logic [1:0]  sync_q;
    logic        rx_s;
    logic [3:0]  os_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        par_bad;
    logic        os_clr, bit_smp, stop_smp;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, overrun_q, frame_err_q;
    logic        deliver;

    // Baud tick: free-running 0..DIV-1, one-cycle tick on the last count.
    assign tick = (div_cnt_q == DivLast);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 16'd1;
        end
    end

    // Two-flop synchronizer, reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end
    assign rx_s = sync_q[1];

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                StIdle:  if (!rx_s) state_d = StStart;
                // Mid start bit: a high line here means the falling edge was a glitch.
                StStart: if (os_cnt_q == 4'd7) state_d = rx_s ? StIdle : StData;
                StData: begin
                    if (os_cnt_q == 4'd15 && bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: if (os_cnt_q == 4'd15) state_d = StStop;
`endif
                StStop:  if (os_cnt_q == 4'd15) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs / datapath strobes
    always_comb begin
        rx_busy  = (state_q != StIdle);
        // os_cnt is held at 0 in idle and restarts after the start-bit sample; elsewhere it
        // simply wraps 15 -> 0, which lines up the next sample 16 ticks later.
        os_clr   = (state_q == StIdle) || (state_q == StStart && os_cnt_q == 4'd7);
        bit_smp  = tick && (state_q == StData) && (os_cnt_q == 4'd15);
        stop_smp = tick && (state_q == StStop) && (os_cnt_q == 4'd15);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (tick) begin
            os_cnt_q <= os_clr ? 4'd0 : os_cnt_q + 4'd1;
            if (state_q == StStart) begin
                bit_cnt_q <= '0;
            end
            if (bit_smp) begin
                shift_q   <= {rx_s, shift_q[7:1]};  // LSB first
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err_q <= 1'b0;
        end else if (tick) begin
            if (state_q == StStart) begin
                par_err_q <= 1'b0;
            end else if (state_q == StParity && os_cnt_q == 4'd15) begin
                par_err_q <= rx_s ^ (^shift_q);  // even parity
            end
        end
    end
    assign par_bad = par_err_q;

    logic parity_err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            // A low stop bit takes precedence: report the framing error only.
            parity_err_q <= stop_smp && rx_s && par_err_q;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Hand-off register
    assign deliver = stop_smp && rx_s && !par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= stop_smp && !rx_s;
            if (deliver) begin
                if (!rx_valid_q || rx_bus.rx_ack) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_bus.rx_ack && rx_valid_q) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data  = rx_data_q;
    assign rx_bus.rx_valid = rx_valid_q;
    assign overrun         = overrun_q;
    assign frame_err       = frame_err_q;

endmodule
